mux7_rr_arbiter: RTL and testbench
==================================

// Module: mux7_rr_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer that shares one 7:1 bit mux among 7 requesters.
//   Drives the mux 3-bit select; code 3'd7 selects the tied-0 spare leg (idle = output 0).
//   Each grant is held until its requester drops req; a new grant goes to the next
//   requester in circular order after the last one served.
// PARAMETERS
//   MAX_HOLD    8   max grant length in cycles (used only when MUX7_TIMEOUT_EN defined); range 1..255
//   GAP_CYCLES  0   extra dead cycles (sel=7) inserted after each release; range 0..15
// PORTS
//   clk        in   1  single clock; all state changes on rising edge
//   rst_n      in   1  synchronous active-low reset, sampled on rising edge of clk
//   en         in   1  1 = new grants allowed; 0 = no new grant; current grant runs to completion
//   req        in   7  request per mux input; req[k] owns mux leg i[k]
//   gnt        out  7  one-hot grant, registered; 0 when idle
//   sel        out  3  mux select, registered; = index of gnt bit, else 3'd7
//   busy       out  1  1 while a grant is active (gnt != 0)
//   timeout    out  1  1-cycle pulse on forced release; constant 0 without MUX7_TIMEOUT_EN
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, gnt=0, sel=3'd7, busy=0, timeout=0, ptr=0, hold_cnt=0, gap_cnt=0.
//     A reset during GRANT or GAP aborts the grant. The cycle after the reset edge shows the reset values.
//   States: IDLE -> GRANT -> (GAP) -> IDLE.
//   IDLE: if en=1 and req!=0, pick first k with req[k]=1, searching ptr, ptr+1, ..., 6, 0, ... (mod 7).
//     At the next edge: gnt=1<<k, sel=k, busy=1, hold_cnt=1, state=GRANT.
//     Latency from req sampled to gnt visible is 1 cycle. If en=0 or req=0, stay IDLE with sel=7.
//   GRANT (owner k): the grant holds while req[k]=1. Other req bits are ignored.
//     hold_cnt increments each cycle and saturates at 255.
//     Release when req[k]=0 is sampled. At the next edge: gnt=0, sel=7, busy=0, ptr=(k==6)?0:k+1.
//     Then state=GAP if GAP_CYCLES>0, else IDLE.
//     The released owner may re-request, but it is lowest priority on the next pass.
//   GAP: sel=7, gnt=0 for GAP_CYCLES cycles (gap_cnt counts down), then IDLE.
//   Minimum dead time between two grants = 1 + GAP_CYCLES cycles with sel=7.
//     The IDLE arbitration cycle always shows sel=7.
//   Invariants:
//     - gnt has at most one bit set.
//     - sel==7 iff gnt==0.
//     - busy == |gnt.
//     - sel is never 7 while busy.
//   en dropping during GRANT has no effect on the current grant.
//   Simultaneous requests: resolved only by the rotating ptr, with no fixed priority.
//   Requests that appear in the release cycle wait for the next IDLE evaluation.
// CONFIGURATION
//   MUX7_TIMEOUT_EN defined:
//     - In GRANT, if hold_cnt==MAX_HOLD with req[k] still 1, release is forced.
//     - The forced release follows the same next-edge actions as a normal release, and timeout=1 for that cycle.
//     - An owner holding req high therefore gets exactly MAX_HOLD consecutive gnt cycles per turn.
//   MUX7_TIMEOUT_EN undefined:
//     - No forced release; the grant lasts as long as req[k] stays high.
//     - The timeout port is tied 0 and MAX_HOLD is unused.
// TESTING
//   1. rst_n=0 two edges with req=7'h7F -> gnt=0, sel=7, busy=0; release rst_n, en=1 -> next edge gnt=7'h01, sel=0.
//   2. req=7'h7F held, each owner drops req after 3 gnt cycles (sets it again later):
//      grant order 0,1,2,3,4,5,6,0; with GAP_CYCLES=0 each owner has sel=k for 3 cycles, then 1 cycle of sel=7.
//   3. Owner 6 granted, then releases with req=7'h41 -> ptr wraps to 0; next grant is 0, not 6.
//   4. With MUX7_TIMEOUT_EN, MAX_HOLD=8, req[2] held high alone:
//      gnt=7'h04 for exactly 8 cycles, timeout pulses once, sel=7 for 1 cycle, then re-granted to 2.
//   5. Grant to 3 active; en=0 and rst_n=0 pulsed for 1 edge mid-grant -> next cycle gnt=0, sel=7, ptr=0.
//      With en=0 held, no further grant until en=1.
//   6. GAP_CYCLES=2, req[1] and req[5] both high, owner 1 releases -> sel=7 for 3 cycles, then gnt=7'h20, sel=5.

Source files
------------

// File: rtl/mux7_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux7_rr_arbiter_if
//  Purpose  : Request/grant bundle between the 7 requesters and the
//             round-robin arbiter that owns the shared 7:1 bit mux select.
//  Signals  : en      - new grants allowed
//             req[6:0]- request per mux leg
//             gnt[6:0]- one-hot registered grant
//             sel[2:0]- registered mux select (3'd7 = idle leg)
//             busy    - grant active
//             timeout - one-cycle pulse on a forced release
//  Modports : master (requester side), slave (arbiter side)
//  Revision : 1.0 - initial release
// ============================================================================
interface mux7_rr_arbiter_if;
    logic       en;
    logic [6:0] req;
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/mux7_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux7_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one 7:1 bit mux among 7 requesters.
//             A grant is held until its owner drops req; the next grant goes
//             to the next requester in circular order after the last owner.
//             Select code 3'd7 picks the tied-0 spare leg (idle).
//  Ports    : clk          - clock, rising edge
//             rst_n        - synchronous active-low reset
//             bus (slave)  - en, req[6:0] in; gnt[6:0], sel[2:0], busy,
//                            timeout out (all outputs registered)
//  Params   : MAX_HOLD   (1..255) max grant length, timeout build only
//             GAP_CYCLES (0..15)  dead cycles inserted after each release
//  Options  : MUX7_TIMEOUT_EN - when defined, a grant held for MAX_HOLD
//             cycles is force-released and timeout pulses for one cycle.
//             When undefined, timeout is constant 0 and MAX_HOLD is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module mux7_rr_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux7_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] c_GAP_CYCLES = 4'(GAP_CYCLES);
    localparam logic [2:0] c_SEL_IDLE   = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [6:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       timeout_q, timeout_d;

    logic       w_found;
    logic [2:0] w_pick;
    logic       w_owner_req;
    logic       w_force;

    // ------------------------------------------------------------------
    // Circular search starting at ptr: ptr, ptr+1, ..., 6, 0, ...
    // ptr is only ever loaded with 0..6, so one subtraction wraps it.
    // ------------------------------------------------------------------
    always_comb begin : p_pick
        logic [3:0] idx;
        w_found = 1'b0;
        w_pick  = 3'd0;
        idx     = 4'd0;
        for (int i = 0; i < 7; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'd7) begin
                idx = idx - 4'd7;
            end
            if (!w_found && bus.req[idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[2:0];
            end
        end
    end

    // The grant is one-hot, so masking req with it isolates the owner's bit
    // without indexing by sel (which would be out of range when idle).
    assign w_owner_req = |(bus.req & gnt_q);

`ifdef MUX7_TIMEOUT_EN
    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);
    // hold_cnt is 1 in the first grant cycle, so reaching MAX_HOLD means
    // the owner has had exactly MAX_HOLD cycles.
    assign w_force = (hold_cnt_q == c_MAX_HOLD);
`else
    logic w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD == 0);
    assign w_force           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'd0;
            hold_cnt_q <= 8'd0;
            gap_cnt_q  <= 4'd0;
            gnt_q      <= 7'd0;
            sel_q      <= c_SEL_IDLE;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            timeout_q  <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_d = 7'd0;
                sel_d = c_SEL_IDLE;
                if (bus.en && w_found) begin
                    gnt_d      = 7'(1) << w_pick;
                    sel_d      = w_pick;
                    hold_cnt_d = 8'd1;
                    state_d    = S_GRANT;
                end
            end

            S_GRANT: begin
                // en is deliberately ignored here: an active grant always
                // runs to completion.
                if (!w_owner_req || w_force) begin
                    gnt_d      = 7'd0;
                    sel_d      = c_SEL_IDLE;
                    hold_cnt_d = 8'd0;
                    timeout_d  = w_owner_req && w_force;
                    // Next search starts just after the released owner, so
                    // that owner becomes lowest priority on the next pass.
                    ptr_d      = (sel_q == 3'd6) ? 3'd0 : 3'(sel_q + 3'd1);
                    gap_cnt_d  = c_GAP_CYCLES;
                    state_d    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            S_GAP: begin
                gnt_d = 7'd0;
                sel_d = c_SEL_IDLE;
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: begin
                gnt_d   = 7'd0;
                sel_d   = c_SEL_IDLE;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mux7_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux7_rr_arbiter
//  Purpose  : Directed self-checking bench for mux7_rr_arbiter. Two
//             instances: u_dut0 (GAP_CYCLES=0) and u_dut1 (GAP_CYCLES=2).
//             Each step drives inputs, pushes the expected post-edge outputs
//             to a scoreboard queue, and pops/compares them after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux7_rr_arbiter;

    logic clk;
    logic rst_n0;
    logic rst_n1;

    mux7_rr_arbiter_if if0 ();
    mux7_rr_arbiter_if if1 ();

    mux7_rr_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (if0)
    );

    mux7_rr_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         dut;
        logic [6:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       tmo;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    // Drive one cycle of stimulus on the selected DUT, record the outputs
    // expected after the next rising edge, then check them 1 time unit later.
    task automatic step(input int d, input logic rn, input logic e,
                        input logic [6:0] r, input logic [6:0] eg,
                        input logic [2:0] es, input logic et,
                        input string tag);
        exp_t        x;
        logic [11:0] obs;
        logic [11:0] exp_v;
        if (d == 0) begin
            rst_n0  = rn;
            if0.en  = e;
            if0.req = r;
        end else begin
            rst_n1  = rn;
            if1.en  = e;
            if1.req = r;
        end
        x.dut  = d;
        x.gnt  = eg;
        x.sel  = es;
        x.busy = (eg != 7'd0);
        x.tmo  = et;
        x.tag  = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (x.dut == 0) obs = {if0.gnt, if0.sel, if0.busy, if0.timeout};
        else            obs = {if1.gnt, if1.sel, if1.busy, if1.timeout};
        exp_v = {x.gnt, x.sel, x.busy, x.tmo};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                   x.tag, obs[11:5], obs[4:2], obs[1], obs[0],
                   exp_v[11:5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
    endtask

    initial begin
        logic [6:0] m;
        logic [6:0] r;
        int         k;

        vectors     = 0;
        miscompares = 0;
        rst_n0      = 1'b0;
        rst_n1      = 1'b0;
        if0.en      = 1'b0;
        if0.req     = 7'h00;
        if1.en      = 1'b0;
        if1.req     = 7'h00;

        // Reset held two edges with all requests up, then first grant to 0.
        step(0, 1'b0, 1'b1, 7'h7F, 7'h00, 3'd7, 1'b0, "reset_a");
        step(0, 1'b0, 1'b1, 7'h7F, 7'h00, 3'd7, 1'b0, "reset_b");
        step(0, 1'b1, 1'b1, 7'h7F, 7'h01, 3'd0, 1'b0, "first_grant");

        // Full rotation 0..6,0: three grant cycles each, one dead cycle.
        for (int n = 0; n < 8; n++) begin
            k = (n == 7) ? 0 : n;
            m = 7'(1) << k;
            if (n > 0)
                step(0, 1'b1, 1'b1, 7'h7F, m, 3'(k), 1'b0, $sformatf("rr_grant%0d", k));
            step(0, 1'b1, 1'b1, 7'h7F, m, 3'(k), 1'b0, $sformatf("rr_hold_a%0d", k));
            step(0, 1'b1, 1'b1, 7'h7F, m, 3'(k), 1'b0, $sformatf("rr_hold_b%0d", k));
            r = 7'h7F & ~m;
            step(0, 1'b1, 1'b1, r, 7'h00, 3'd7, 1'b0, $sformatf("rr_release%0d", k));
        end

        // Owner 6 releases; pointer wraps so 0 wins over 6.
        step(0, 1'b1, 1'b1, 7'h40, 7'h40, 3'd6, 1'b0, "own6_grant");
        step(0, 1'b1, 1'b1, 7'h40, 7'h40, 3'd6, 1'b0, "own6_hold");
        step(0, 1'b1, 1'b1, 7'h01, 7'h00, 3'd7, 1'b0, "own6_release");
        step(0, 1'b1, 1'b1, 7'h41, 7'h01, 3'd0, 1'b0, "wrap_to_0");
        step(0, 1'b1, 1'b1, 7'h40, 7'h00, 3'd7, 1'b0, "own0_release");

        // Grant 3, en drop has no effect, mid-grant reset aborts.
        step(0, 1'b1, 1'b1, 7'h08, 7'h08, 3'd3, 1'b0, "grant3");
        step(0, 1'b1, 1'b0, 7'h08, 7'h08, 3'd3, 1'b0, "en_low_holds");
        step(0, 1'b0, 1'b0, 7'h08, 7'h00, 3'd7, 1'b0, "mid_reset");
        for (int n = 0; n < 3; n++)
            step(0, 1'b1, 1'b0, 7'h7F, 7'h00, 3'd7, 1'b0, "en_low_idle");
        // ptr must be 0 again after reset: all requesting -> 0 wins.
        step(0, 1'b1, 1'b1, 7'h7F, 7'h01, 3'd0, 1'b0, "ptr_reset");
        step(0, 1'b1, 1'b1, 7'h04, 7'h00, 3'd7, 1'b0, "rel0");

        // Requester 2 holds req high alone.
        step(0, 1'b1, 1'b1, 7'h04, 7'h04, 3'd2, 1'b0, "hold2_grant");
`ifdef MUX7_TIMEOUT_EN
        for (int n = 2; n <= 8; n++)
            step(0, 1'b1, 1'b1, 7'h04, 7'h04, 3'd2, 1'b0, $sformatf("hold2_cyc%0d", n));
        step(0, 1'b1, 1'b1, 7'h04, 7'h00, 3'd7, 1'b1, "forced_release");
        step(0, 1'b1, 1'b1, 7'h04, 7'h04, 3'd2, 1'b0, "regrant2");
`else
        for (int n = 2; n <= 12; n++)
            step(0, 1'b1, 1'b1, 7'h04, 7'h04, 3'd2, 1'b0, $sformatf("hold2_cyc%0d", n));
`endif
        step(0, 1'b1, 1'b1, 7'h00, 7'h00, 3'd7, 1'b0, "rel2");
        step(0, 1'b1, 1'b1, 7'h00, 7'h00, 3'd7, 1'b0, "idle_no_req");

        // GAP_CYCLES=2 instance: 3 dead cycles after release, then 5.
        step(1, 1'b0, 1'b0, 7'h00, 7'h00, 3'd7, 1'b0, "d1_reset");
        step(1, 1'b1, 1'b1, 7'h22, 7'h02, 3'd1, 1'b0, "d1_grant1");
        step(1, 1'b1, 1'b1, 7'h22, 7'h02, 3'd1, 1'b0, "d1_hold1");
        step(1, 1'b1, 1'b1, 7'h20, 7'h00, 3'd7, 1'b0, "d1_release");
        step(1, 1'b1, 1'b1, 7'h20, 7'h00, 3'd7, 1'b0, "d1_gap_a");
        step(1, 1'b1, 1'b1, 7'h20, 7'h00, 3'd7, 1'b0, "d1_gap_b");
        step(1, 1'b1, 1'b1, 7'h20, 7'h20, 3'd5, 1'b0, "d1_grant5");
        step(1, 1'b1, 1'b1, 7'h20, 7'h20, 3'd5, 1'b0, "d1_hold5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
